// File: rtl/rv32im_pkg.sv
// Shared definitions for the RV32M divide unit: FSM states, default width and
// the result constants used for divide-by-zero and signed overflow.
package rv32im_pkg;

   localparam int DEFAULT_XLEN = 32;

   localparam logic [DEFAULT_XLEN-1:0] DIV_BY_ZERO_Q       = {DEFAULT_XLEN{1'b1}};
   localparam logic [DEFAULT_XLEN-1:0] SIGNED_OVF_DIVIDEND = {1'b1, {(DEFAULT_XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/rv32im_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the
// divisor, and keep the difference only when it did not go negative.
module rv32im_div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN:0]   rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN:0]   rem_next,
   output logic [XLEN-1:0] quo_next
);

   logic [XLEN+1:0] shifted;
   logic [XLEN+1:0] trial;
   logic            negative;

   // One extra bit above the partial remainder keeps the borrow unambiguous.
   assign shifted  = {rem, quo[XLEN-1]};
   assign trial    = shifted - {2'b00, divisor};
   assign negative = trial[XLEN+1];

   assign rem_next = negative ? shifted[XLEN:0] : trial[XLEN:0];
   assign quo_next = {quo[XLEN-2:0], ~negative};

endmodule

// File: rtl/rv32im_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU. Works on operand
// magnitudes and re-applies the signs in a single fix-up cycle at the end.
module rv32im_div
   import rv32im_pkg::*;
#(
   parameter int XLEN = DEFAULT_XLEN
) (
   input  logic            clk_i,
   input  logic            reset_ni,
   input  logic            start_i,
   input  logic            signed_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic            busy_o,
   output logic            valid_o,
   output logic [XLEN-1:0] quotient_o,
   output logic [XLEN-1:0] remainder_o
);

   localparam int              CW           = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] ALL_ONES     = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] OVF_DIVIDEND = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e      state, state_next;
   logic [CW-1:0]   counter, counter_next;
   logic [XLEN:0]   rem, rem_next;
   logic [XLEN-1:0] quo, quo_next;
   logic [XLEN-1:0] div_q, div_next;
   logic            neg_q, neg_q_next;
   logic            neg_r, neg_r_next;
   logic            busy_next, valid_next;
   logic [XLEN-1:0] quotient_next, remainder_next;

   logic [XLEN:0]   step_rem;
   logic [XLEN-1:0] step_quo;
   logic            dividend_neg, divisor_neg;

   rv32im_div_step #(.XLEN(XLEN)) u_step (
      .rem      (rem),
      .quo      (quo),
      .divisor  (div_q),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   // Only two's-complement operations may treat a set MSB as a sign.
   assign dividend_neg = signed_i & dividend_i[XLEN-1];
   assign divisor_neg  = signed_i & divisor_i[XLEN-1];

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state       <= IDLE;
         counter     <= '0;
         rem         <= '0;
         quo         <= '0;
         div_q       <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         busy_o      <= 1'b0;
         valid_o     <= 1'b0;
         quotient_o  <= '0;
         remainder_o <= '0;
      end else begin
         state       <= state_next;
         counter     <= counter_next;
         rem         <= rem_next;
         quo         <= quo_next;
         div_q       <= div_next;
         neg_q       <= neg_q_next;
         neg_r       <= neg_r_next;
         busy_o      <= busy_next;
         valid_o     <= valid_next;
         quotient_o  <= quotient_next;
         remainder_o <= remainder_next;
      end
   end

   // A start pulse wins in every state, so an in-flight operation is simply dropped.
   always_comb begin
      state_next     = state;
      counter_next   = counter;
      rem_next       = rem;
      quo_next       = quo;
      div_next       = div_q;
      neg_q_next     = neg_q;
      neg_r_next     = neg_r;
      busy_next      = busy_o;
      valid_next     = valid_o;
      quotient_next  = quotient_o;
      remainder_next = remainder_o;

      if (start_i) begin
         if (divisor_i == '0) begin
            quotient_next  = ALL_ONES;
            remainder_next = dividend_i;
            busy_next      = 1'b0;
            valid_next     = 1'b1;
            state_next     = DONE;
         end else if (signed_i && dividend_i == OVF_DIVIDEND && divisor_i == ALL_ONES) begin
            quotient_next  = dividend_i;
            remainder_next = '0;
            busy_next      = 1'b0;
            valid_next     = 1'b1;
            state_next     = DONE;
         end else begin
            neg_q_next   = dividend_neg ^ divisor_neg;
            neg_r_next   = dividend_neg;
            quo_next     = dividend_neg ? -dividend_i : dividend_i;
            div_next     = divisor_neg ? -divisor_i : divisor_i;
            rem_next     = '0;
            counter_next = '0;
            busy_next    = 1'b1;
            valid_next   = 1'b0;
            state_next   = CALC;
         end
      end else begin
         case (state)
            CALC: begin
               rem_next     = step_rem;
               quo_next     = step_quo;
               counter_next = counter + CW'(1);
               if (counter == CW'(XLEN - 1)) begin
                  state_next = FIX;
               end
            end
            FIX: begin
               quotient_next  = neg_q ? -quo : quo;
               remainder_next = neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
               busy_next      = 1'b0;
               valid_next     = 1'b1;
               state_next     = DONE;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv32im_div.sv
// Self-checking bench for rv32im_div: directed vector table, randomized ops
// against an arithmetic reference model, plus restart and reset sequences.
module tb_rv32im_div;
   import rv32im_pkg::*;

   localparam int NORMAL_LATENCY = 33;
   localparam int WAIT_LIMIT     = 40;

   logic        clk;
   logic        resetN;
   logic        start;
   logic        signedIn;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        valid;
   logic [31:0] quotient;
   logic [31:0] remainder;

   int assertions = 0;
   int failures   = 0;

   rv32im_div #(.XLEN(32)) dut (
      .clk_i       (clk),
      .reset_ni    (resetN),
      .start_i     (start),
      .signed_i    (signedIn),
      .dividend_i  (dividend),
      .divisor_i   (divisor),
      .busy_o      (busy),
      .valid_o     (valid),
      .quotient_o  (quotient),
      .remainder_o (remainder)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] expQ;
      logic [31:0] expR;
      logic        special;
   } vec_t;

   vec_t vecs[13];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertions++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Reference: the architectural RV32M rules in plain arithmetic.
   function automatic void refModel(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r, output logic special);
      if (b == 32'd0) begin
         q = DIV_BY_ZERO_Q;
         r = a;
         special = 1'b1;
      end else if (s && a == SIGNED_OVF_DIVIDEND && b == 32'hFFFF_FFFF) begin
         q = a;
         r = 32'd0;
         special = 1'b1;
      end else if (s) begin
         q = 32'($signed(a) / $signed(b));
         r = 32'($signed(a) % $signed(b));
         special = 1'b0;
      end else begin
         q = a / b;
         r = a % b;
         special = 1'b0;
      end
   endfunction

   // Drives one start pulse and waits (bounded) for valid; latency counts edges after the start edge.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output int latency, output logic busySeen, output logic busyAtValid);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      signedIn = s;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      latency  = 0;
      busySeen = busy;
      while (!valid && latency < WAIT_LIMIT) begin
         @(posedge clk);
         #1;
         latency++;
         busySeen = busySeen | busy;
      end
      busyAtValid = busy;
   endtask

   task automatic runAndCheck(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                              input logic [31:0] expQ, input logic [31:0] expR, input logic special);
      int   latency;
      logic busySeen, busyAtValid;
      applyStimulus(a, b, s, latency, busySeen, busyAtValid);
      checkOutput({tag, " quotient"}, quotient, expQ);
      checkOutput({tag, " remainder"}, remainder, expR);
      checkOutput({tag, " latency"}, 32'(latency), special ? 32'd0 : 32'(NORMAL_LATENCY));
      checkOutput({tag, " busy seen"}, {31'd0, busySeen}, {31'd0, ~special});
      checkOutput({tag, " busy at valid"}, {31'd0, busyAtValid}, 32'd0);
   endtask

   initial begin
      logic [31:0] a, b, mq, mr;
      logic        s, msp;
      logic        sawValid;
      int          latency;

      vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0};
      vecs[1]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
      vecs[2]  = '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0};
      vecs[3]  = '{32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF, 32'd5,         1'b1};
      vecs[4]  = '{32'd5,         32'd0,         1'b1, 32'hFFFF_FFFF, 32'd5,         1'b1};
      vecs[5]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b1};
      vecs[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 1'b0};
      vecs[7]  = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'd0,         1'b0};
      vecs[8]  = '{32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 32'd2,         32'hFFFF_FFFE, 1'b0};
      vecs[9]  = '{32'hFFFF_FFFF, 32'd2,         1'b0, 32'h7FFF_FFFF, 32'd1,         1'b0};
      vecs[10] = '{32'd0,         32'd5,         1'b1, 32'd0,         32'd0,         1'b0};
      vecs[11] = '{32'h8000_0000, 32'd1,         1'b1, 32'h8000_0000, 32'd0,         1'b0};
      vecs[12] = '{32'h8000_0000, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};

      resetN   = 1'b0;
      start    = 1'b0;
      signedIn = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      checkOutput("reset valid", {31'd0, valid}, 32'd0);
      checkOutput("reset quotient", quotient, 32'd0);
      checkOutput("reset remainder", remainder, 32'd0);
      @(negedge clk);
      resetN = 1'b1;

      for (int i = 0; i < 13; i++) begin
         runAndCheck($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                     vecs[i].expQ, vecs[i].expR, vecs[i].special);
         repeat (2) @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d valid hold", i), {31'd0, valid}, 32'd1);
         checkOutput($sformatf("vec%0d quotient hold", i), quotient, vecs[i].expQ);
      end

      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1, 2:    b = 32'($urandom_range(1, 16));
            3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: b = $urandom;
         endcase
         s = 1'($urandom_range(0, 1));
         refModel(a, b, s, mq, mr, msp);
         runAndCheck($sformatf("rand%0d", i), a, b, s, mq, mr, msp);
      end

      // Restart mid-CALC: only the second operation may ever report valid.
      @(negedge clk);
      dividend = 32'd1000;
      divisor  = 32'd3;
      signedIn = 1'b0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      sawValid = valid;
      repeat (9) begin
         @(posedge clk);
         #1;
         sawValid = sawValid | valid;
      end
      @(negedge clk);
      dividend = 32'd9;
      divisor  = 32'd4;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      latency  = 0;
      sawValid = sawValid | valid;
      while (!valid && latency < WAIT_LIMIT) begin
         @(posedge clk);
         #1;
         latency++;
      end
      checkOutput("restart early valid", {31'd0, sawValid}, 32'd0);
      checkOutput("restart latency", 32'(latency), 32'(NORMAL_LATENCY));
      checkOutput("restart quotient", quotient, 32'd2);
      checkOutput("restart remainder", remainder, 32'd1);

      // Asynchronous reset mid-CALC clears everything and suppresses the result.
      @(negedge clk);
      dividend = 32'd1000;
      divisor  = 32'd3;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      resetN = 1'b0;
      #1;
      checkOutput("async reset busy", {31'd0, busy}, 32'd0);
      checkOutput("async reset valid", {31'd0, valid}, 32'd0);
      checkOutput("async reset quotient", quotient, 32'd0);
      checkOutput("async reset remainder", remainder, 32'd0);
      @(negedge clk);
      resetN   = 1'b1;
      sawValid = 1'b0;
      repeat (WAIT_LIMIT) begin
         @(posedge clk);
         #1;
         sawValid = sawValid | valid | busy;
      end
      checkOutput("post reset idle", {31'd0, sawValid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
